// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU host-write path: table select,
// VGA frame geometry and the buffered host-write entry.
package ppu_pkg;

  typedef enum logic [1:0] {
    TBL_ATTR   = 2'b00,
    TBL_SPRITE = 2'b01,
    TBL_COLOR  = 2'b10,
    TBL_CTRL   = 2'b11
  } tbl_sel_e;

  localparam int PPU_VACTIVE = 480;
  localparam int PPU_VTOTAL  = 525;

  // Field order matches the push of {address[9:0], writedata}.
  typedef struct packed {
    tbl_sel_e    sel;
    logic [7:0]  addr;
    logic [31:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/ppu_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read and occupancy count.
// Push while full and pop while empty are ignored.
module ppu_sync_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ppu_write_scheduler.sv
// Buffers host table writes and replays them into the PPU tables only during
// vertical blanking. Optional PPU_WS_FRAME_COMMIT_EN gates drains on a control-write commit.
module ppu_write_scheduler
  import ppu_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int VACTIVE    = PPU_VACTIVE,
  parameter int DRAIN_LAST = 523
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          chipselect,
  input  logic                          write,
  input  logic [15:0]                   address,
  input  logic [31:0]                   writedata,
  output logic                          waitrequest,
  input  logic [10:0]                   hcount,
  input  logic [9:0]                    vcount,
  output logic [2:0]                    mem_we,
  output logic [7:0]                    mem_addr,
  output logic [31:0]                   mem_data,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          drained
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = $bits(fifo_entry_t);
  localparam logic [9:0] V_LO = 10'(VACTIVE);
  localparam logic [9:0] V_HI = 10'(DRAIN_LAST);

  typedef enum logic [1:0] {IDLE, WAIT_WIN, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [2:0]      mem_we_q, mem_we_d;
  logic [7:0]      mem_addr_q, mem_addr_d;
  logic [31:0]     mem_data_q, mem_data_d;
  logic            drained_q, drained_d;

  logic            accept, is_ctrl, fifo_push, pop;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [EW-1:0]   fifo_wdata, fifo_rdata;
  fifo_entry_t     head;
  logic            in_window, armed, last_pop;
  logic [CW-1:0]   avail;
  logic            unused_ok;

  assign unused_ok = ^{hcount, address[15:10], fifo_empty};

  assign accept    = chipselect && write && !fifo_full;
  assign is_ctrl   = (address[9:8] == 2'b11);
  assign fifo_push = accept && !is_ctrl;
  assign fifo_wdata = {address[9:0], writedata};
  assign head      = fifo_entry_t'(fifo_rdata);
  assign in_window = (vcount >= V_LO) && (vcount <= V_HI);

`ifdef PPU_WS_FRAME_COMMIT_EN
  // Number of entries covered by the latest commit; nonzero acts as the commit flag.
  logic          ctrl_acc;
  logic [CW-1:0] commit_cnt_q, commit_cnt_d;

  assign ctrl_acc = accept && is_ctrl;
  assign avail    = commit_cnt_q;
  assign armed    = (commit_cnt_q != '0);
  assign last_pop = pop && (commit_cnt_d == '0);

  always_comb begin
    commit_cnt_d = commit_cnt_q - CW'(pop);
    if (ctrl_acc) commit_cnt_d = fifo_count - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) commit_cnt_q <= '0;
    else       commit_cnt_q <= commit_cnt_d;
  end
`else
  assign avail    = fifo_count;
  assign armed    = 1'b1;
  assign last_pop = pop && (fifo_count == CW'(1)) && !fifo_push;
`endif

  assign pop = (state_q == DRAIN) && in_window && (avail != '0);

  ppu_sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (fifo_count != '0) state_d = WAIT_WIN;
      WAIT_WIN: if (in_window && armed) state_d = DRAIN;
      DRAIN: begin
        if (avail == '0)     state_d = (fifo_count != '0) ? WAIT_WIN : IDLE;
        else if (!in_window) state_d = WAIT_WIN;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_we_d   = 3'b000;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    drained_d  = last_pop;
    if (pop) begin
      mem_data_d = head.data;
      case (head.sel)
        TBL_ATTR:   begin mem_we_d = 3'b001; mem_addr_d = {4'b0, head.addr[3:0]}; end
        TBL_SPRITE: begin mem_we_d = 3'b010; mem_addr_d = head.addr;              end
        TBL_COLOR:  begin mem_we_d = 3'b100; mem_addr_d = {4'b0, head.addr[3:0]}; end
        default:    mem_we_d = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_we_q   <= 3'b000;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      drained_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      drained_q  <= drained_d;
    end
  end

  assign waitrequest = fifo_full;
  assign pending     = fifo_count;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign drained     = drained_q;

endmodule

// File: tb/tb_ppu_write_scheduler.sv
// Bench for ppu_write_scheduler: an ordered scoreboard of accepted writes checked
// every cycle, plus directed frame-position scenarios with literal expectations.
module tb_ppu_write_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0, write = 1'b0;
  logic [15:0] address = '0;
  logic [31:0] writedata = '0;
  logic        waitrequest;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic [2:0]  mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic [4:0]  pending;
  logic        drained;

  int total = 0, bad = 0, cyc = 0;

  ppu_write_scheduler dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
    .address(address), .writedata(writedata), .waitrequest(waitrequest),
    .hcount(hcount), .vcount(vcount), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .pending(pending), .drained(drained)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit in_win(input int v);
    return (v >= 480) && (v <= 523);
  endfunction

  // Scoreboard: entries the DUT has accepted, oldest first.
  typedef struct { logic [9:0] a; logic [31:0] d; } ent_t;
  typedef struct { logic [2:0] we; logic [7:0] addr; logic [31:0] data; int pv; int cyc; } log_t;
  ent_t q[$];
  log_t lg[$];
  bit   push_pend = 0;
  ent_t push_ent;
  logic [7:0]  last_addr = '0;
  logic [31:0] last_data = '0;
  int   prev_vc = 0, stall = 0, n_drained = 0, acc_cyc = 0;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      push_pend = 0;
      last_addr = '0;
      last_data = '0;
      stall = 0;
    end else begin
      if (push_pend) q.push_back(push_ent);
      push_pend = 0;
      if (mem_we != 3'b000) begin
        lg.push_back('{mem_we, mem_addr, mem_data, prev_vc, cyc});
        if (q.size() == 0) chk("write_with_empty_model", 64'(mem_we), 64'(0));
        else begin
          ent_t e;
          logic [2:0] ew;
          logic [7:0] ea;
          e  = q.pop_front();
          ew = 3'b001 << e.a[9:8];
          ea = (e.a[9:8] == 2'b01) ? e.a[7:0] : {4'b0, e.a[3:0]};
          chk("mem_we", 64'(mem_we), 64'(ew));
          chk("mem_addr", 64'(mem_addr), 64'(ea));
          chk("mem_data", 64'(mem_data), 64'(e.d));
          chk("pop_in_window", 64'(in_win(prev_vc)), 64'(1));
          last_addr = ea;
          last_data = e.d;
        end
      end else begin
        chk("hold_addr", 64'(mem_addr), 64'(last_addr));
        chk("hold_data", 64'(mem_data), 64'(last_data));
      end
`ifndef PPU_WS_FRAME_COMMIT_EN
      chk("drained", 64'(drained), 64'((mem_we != 3'b000) && (q.size() == 0)));
      if (q.size() != 0 && in_win(vcount) && mem_we == 3'b000) stall++;
      else stall = 0;
      if (stall == 6) chk("drain_stall", 64'(stall), 64'(0));
`endif
      chk("pending", 64'(pending), 64'(q.size()));
      chk("waitrequest", 64'(waitrequest), 64'(q.size() == 16));
      if (drained) n_drained++;
      if (chipselect && write && !waitrequest && address[9:8] != 2'b11) begin
        push_pend = 1;
        push_ent  = '{address[9:0], writedata};
      end
      prev_vc = vcount;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (hcount == 11'd1599) begin
      hcount = '0;
      vcount = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
    end else hcount = hcount + 11'd1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_pos(input int v, input int h);
    vcount = 10'(v);
    hcount = 11'(h);
  endtask

  task automatic host_wr(input logic [15:0] a, input logic [31:0] d);
    bit acc = 0;
    chipselect = 1; write = 1; address = a; writedata = d;
    for (int n = 0; n < 5000 && !acc; n++) begin
      @(negedge clk);
      acc = !waitrequest;
      if (acc) acc_cyc = cyc;
      tick();
    end
    chipselect = 0; write = 0;
    if (!acc) chk("write_timeout", 64'(0), 64'(1));
  endtask

  task automatic do_reset();
    reset = 1;
    ticks(2);
    reset = 0;
    tick();
  endtask

  initial begin
    int n0, d0;
    // Reset state
    ticks(3);
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_pending", 64'(pending), 64'(0));
    reset = 0;
    tick();
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_data", 64'(mem_data), 64'(0));
    chk("rst_drained", 64'(drained), 64'(0));
    chk("rst_waitrequest", 64'(waitrequest), 64'(0));

    // Three table writes during active video, released at vblank
    set_pos(100, 0);
    host_wr(16'h0002, 32'hA0A0_0001);
    host_wr(16'h0105, 32'hB0B0_0002);
    host_wr(16'h0203, 32'hC0C0_0003);
    chk("s1_pending", 64'(pending), 64'(3));
    host_wr(16'h0300, 32'h0000_0001);
    chk("s1_ctrl_no_push", 64'(pending), 64'(3));
    n0 = lg.size(); d0 = n_drained;
    ticks(200);
    chk("s1_no_early_we", 64'(lg.size()), 64'(n0));
    set_pos(479, 1595);
    ticks(30);
    chk("s1_count", 64'(lg.size() - n0), 64'(3));
    if (lg.size() >= n0 + 3) begin
      chk("s1_we0", 64'(lg[n0].we), 64'(3'b001));
      chk("s1_we1", 64'(lg[n0+1].we), 64'(3'b010));
      chk("s1_we2", 64'(lg[n0+2].we), 64'(3'b100));
      chk("s1_addr0", 64'(lg[n0].addr), 64'(8'h02));
      chk("s1_addr1", 64'(lg[n0+1].addr), 64'(8'h05));
      chk("s1_addr2", 64'(lg[n0+2].addr), 64'(8'h03));
      chk("s1_consec", 64'(lg[n0+2].cyc - lg[n0].cyc), 64'(2));
      chk("s1_after_480", 64'(lg[n0].pv >= 480), 64'(1));
    end
    chk("s1_drained_once", 64'(n_drained - d0), 64'(1));

`ifndef PPU_WS_FRAME_COMMIT_EN
    // 17 back-to-back writes: the 17th waits for the first pop
    do_reset();
    set_pos(100, 0);
    for (int i = 0; i < 16; i++) begin
      host_wr(16'h0100 | 16'(i), 32'h1700_0000 + 32'(i));
      if (i == 14) chk("s2_not_full_15", 64'(waitrequest), 64'(0));
    end
    chk("s2_full_16", 64'(waitrequest), 64'(1));
    chk("s2_pending16", 64'(pending), 64'(16));
    n0 = lg.size();
    set_pos(479, 1598);
    host_wr(16'h0011, 32'hDEAD_0017);
    if (lg.size() > n0) chk("s2_acc_on_first_pop", 64'(acc_cyc), 64'(lg[n0].cyc));
    ticks(40);
    chk("s2_all_drained", 64'(lg.size() - n0), 64'(17));
    chk("s2_last_data", 64'(lg[lg.size()-1].data), 64'(32'hDEAD_0017));
    chk("s2_pending0", 64'(pending), 64'(0));

    // Window entered at the last permitted line: partial drain, rest next frame
    do_reset();
    set_pos(100, 0);
    for (int i = 0; i < 16; i++) host_wr(16'h0200 | 16'(i), 32'h3400_0000 + 32'(i));
    n0 = lg.size(); d0 = n_drained;
    set_pos(523, 1589);
    ticks(30);
    chk("s3_pops_523", 64'(lg.size() - n0), 64'(10));
    chk("s3_pending6", 64'(pending), 64'(6));
    chk("s3_no_drained", 64'(n_drained - d0), 64'(0));
    set_pos(479, 1598);
    ticks(20);
    chk("s3_rest", 64'(lg.size() - n0), 64'(16));
    chk("s3_drained", 64'(n_drained - d0), 64'(1));

    // Reset while draining with 5 entries left
    do_reset();
    set_pos(100, 0);
    for (int i = 0; i < 12; i++) host_wr(16'h0000 | 16'(i), 32'h5500_0000 + 32'(i));
    set_pos(480, 0);
    for (int n = 0; n < 60 && pending != 5'd5; n++) tick();
    chk("s4_reached5", 64'(pending), 64'(5));
    #1 reset = 1;
    #1;
    chk("s4_we0", 64'(mem_we), 64'(0));
    chk("s4_pending0", 64'(pending), 64'(0));
    chk("s4_addr0", 64'(mem_addr), 64'(0));
    n0 = lg.size();
    ticks(2);
    reset = 0;
    ticks(40);
    chk("s4_no_writes", 64'(lg.size()), 64'(n0));
    chk("s4_pending_after", 64'(pending), 64'(0));

    // Simultaneous push and pop at pending 8
    do_reset();
    set_pos(100, 0);
    for (int i = 0; i < 9; i++) host_wr(16'h0100 | 16'(i), 32'h3700_0000 + 32'(i));
    set_pos(480, 0);
    for (int n = 0; n < 40 && pending != 5'd8; n++) tick();
    chk("s5_at8", 64'(pending), 64'(8));
    host_wr(16'h0020, 32'h3737_3737);
    chk("s5_still8", 64'(pending), 64'(8));
    ticks(20);
    chk("s5_pending0", 64'(pending), 64'(0));
`else
    // Frame commit: nothing drains until a control write arrives
    do_reset();
    set_pos(100, 0);
    for (int i = 0; i < 4; i++) host_wr(16'h0000 | 16'(i), 32'h3600_0000 + 32'(i));
    n0 = lg.size(); d0 = n_drained;
    set_pos(480, 0);
    ticks(40);
    set_pos(500, 0);
    ticks(40);
    chk("c_no_we", 64'(lg.size()), 64'(n0));
    chk("c_pending4", 64'(pending), 64'(4));
    set_pos(100, 0);
    host_wr(16'h0300, 32'h0);
    host_wr(16'h0207, 32'h3600_00FF);
    chk("c_pending5", 64'(pending), 64'(5));
    set_pos(479, 1598);
    ticks(20);
    chk("c_drained4", 64'(lg.size() - n0), 64'(4));
    chk("c_left1", 64'(pending), 64'(1));
    chk("c_drained_pulse", 64'(n_drained - d0), 64'(1));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ppu_write_scheduler.md
PPU_WRITE_SCHEDULER -- requirements
Module: ppu_write_scheduler

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 16, host-write buffer entries (power of 2, at least 4).
REQ-002 The block SHALL have parameter VACTIVE, default 480, first non-visible line.
REQ-003 The block SHALL have parameter DRAIN_LAST, default 523, last line on which table writes are permitted.
REQ-004 The block SHALL have port clk, input, 1, system clock (50 MHz).
REQ-005 The block SHALL have port reset, input, 1, asynchronous, active-high.
REQ-006 The block SHALL have port chipselect, input, 1, host bus select.
REQ-007 The block SHALL have port write, input, 1, host write strobe.
REQ-008 The block SHALL have port address, input, 16, host address; bits [9:8] select the table: 00 attr, 01 sprite, 10 color, 11 control.
REQ-009 The block SHALL have port writedata, input, 32, host write data.
REQ-010 The block SHALL have port waitrequest, output, 1, high while the FIFO is full.
REQ-011 The block SHALL have ports hcount, input, 11, and vcount, input, 10, driven from the shared VGA counters.
REQ-012 The block SHALL have port mem_we, output, 3, one-hot table write enable: bit0 attr, bit1 sprite, bit2 color.
REQ-013 The block SHALL have port mem_addr, output, 8, table address.
REQ-014 The block SHALL have port mem_data, output, 32, table write data.
REQ-015 The block SHALL have port pending, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-016 The block SHALL have port drained, output, 1, one-cycle pulse when a drain window empties the FIFO.

Function
REQ-017 A host write SHALL be accepted iff chipselect && write && !waitrequest; each accepted write pushes {address[9:0], writedata} in the same cycle.
REQ-018 Control-table writes (address[9:8]=11) SHALL be handled per REQ-028/029 and SHALL never assert mem_we.
REQ-019 The FSM SHALL have three states: IDLE, WAIT_WIN, DRAIN; reset state IDLE.
REQ-020 IDLE -> WAIT_WIN when pending!=0; WAIT_WIN -> DRAIN when VACTIVE <= vcount <= DRAIN_LAST and the drain is armed; DRAIN -> IDLE when the FIFO is empty; DRAIN -> WAIT_WIN when vcount leaves the window with entries remaining.
REQ-021 In DRAIN, exactly one entry SHALL pop per cycle while the FIFO is non-empty; mem_we/mem_addr/mem_data are registered and valid the cycle after the pop.
REQ-022 mem_addr SHALL carry address[3:0] zero-extended for attr and color, and address[7:0] for sprite.
REQ-023 Outside DRAIN, mem_we SHALL be 3'b000 and mem_addr/mem_data SHALL hold their last value.
REQ-024 A push and a pop in the same cycle SHALL leave pending unchanged; no push occurs while full, and no pop occurs while empty.
REQ-025 drained SHALL pulse in the cycle mem_we carries the last entry of a window that emptied the FIFO.
REQ-026 Writes accepted during DRAIN SHALL be drained within the same window when time permits; FIFO order SHALL be preserved.

Reset
REQ-027 Asynchronous reset SHALL clear the FIFO, set state IDLE, mem_we=0, mem_addr=0, mem_data=0, drained=0, and pending=0; reset mid-DRAIN SHALL discard remaining entries with no partial write.

Configuration
REQ-028 With PPU_WS_FRAME_COMMIT_EN defined, a control write SHALL set a commit flag, the drain SHALL be armed only when the flag is set, the flag SHALL clear on drained, and entries pushed after the commit SHALL wait for the next commit.
REQ-029 Without PPU_WS_FRAME_COMMIT_EN, the drain SHALL always be armed and control writes SHALL be accepted and discarded without a push.

Structure
REQ-030 ppu_pkg SHALL hold the table-select enum (TBL_ATTR, TBL_SPRITE, TBL_COLOR, TBL_CTRL), the VACTIVE/VTOTAL constants, and the FIFO entry struct {sel, addr, data}.
REQ-031 The design SHALL have one sub-module, ppu_sync_fifo: parameterised width/depth, single clock, full/empty/count outputs.

Verification
REQ-032 Scenario: 3 writes (attr 0x0002, sprite 0x0105, color 0x0203) at vcount=100 -> no mem_we before vcount=480; then mem_we = 001, 010, 100 on consecutive cycles with addrs 0x02, 0x05, 0x03; drained pulses once.
REQ-033 Scenario: 17 back-to-back writes with FIFO_DEPTH=16 outside the window -> waitrequest high after the 16th; the 17th is held and accepted on the first pop cycle.
REQ-034 Scenario: 16 entries, window entered at vcount=523, hcount=1590 -> 10 pops, then stop at vcount=524; the remaining 6 drain in the next frame's window.
REQ-035 Scenario: reset asserted during DRAIN with 5 entries left -> mem_we=0 immediately, pending=0, and no further writes.
REQ-036 Scenario (macro defined): 4 writes without commit across two vblanks -> no mem_we; a control write at 0x0300 -> drain in the next window.
REQ-037 Scenario: push and pop in the same cycle at pending=8 -> pending stays 8.
